// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples nSS/SCLK/MOSI in the MHZ48 domain, shifts bytes
// MSB first, and exposes an RX byte strobe plus a one-entry TX holding register.
module spi_target #(
    parameter logic [7:0] FILL        = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       MHZ48,
    input  logic       RES,
    input  logic       nSS,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_OE,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       UNDERRUN,
    output logic       BUSY
);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_ss_d;
    logic                   r_sclk_d;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [7:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [7:0] r_hold;
    logic       r_hold_full;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_underrun;

    logic w_ss;
    logic w_sclk;
    logic w_mosi;
    logic w_ss_fall;
    logic w_ss_rise;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_shifting;
    logic w_load;
    logic w_rx_bit;
    logic w_tx_bit;
    logic w_accept;

    // nSS chain resets high so a released reset never looks like a selection
    always_ff @(posedge MHZ48) begin
        if (RES) begin
            r_ss_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_d      <= 1'b1;
            r_sclk_d    <= 1'b0;
        end else begin
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], nSS};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_ss_d      <= w_ss;
            r_sclk_d    <= w_sclk;
        end
    end

    assign w_ss        = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_fall   = r_ss_d & ~w_ss;
    assign w_ss_rise   = ~r_ss_d & w_ss;
    assign w_sclk_rise = ~r_sclk_d & w_sclk;
    assign w_sclk_fall = r_sclk_d & ~w_sclk;

    // A deselect in the same cycle as an SCLK edge masks that edge
    assign w_shifting = (r_state == ST_SHIFT) & ~w_ss_rise;
    assign w_rx_bit   = w_shifting & w_sclk_rise;
    assign w_tx_bit   = w_shifting & w_sclk_fall & (r_cnt != 3'd0);
    assign w_load     = ((r_state == ST_IDLE) & w_ss_fall) |
                        (w_shifting & w_sclk_fall & (r_cnt == 3'd0));
    assign w_accept   = TX_VALID & ~r_hold_full;

    always_ff @(posedge MHZ48) begin
        if (RES) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_ss_fall) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_ss_rise) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge MHZ48) begin
        if (RES) begin
            r_cnt       <= 3'd0;
            r_rx_shift  <= 8'h00;
            r_tx_shift  <= 8'h00;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;

            if (w_accept) begin
                r_hold      <= TX_DATA;
                r_hold_full <= 1'b1;
            end

            // LOAD only sees the registered full flag; a same-cycle accept waits
            if (w_load) begin
                if (r_hold_full) begin
                    r_tx_shift  <= r_hold;
                    r_hold_full <= 1'b0;
                end else begin
                    r_tx_shift <= FILL;
                    r_underrun <= 1'b1;
                end
            end else if (w_tx_bit) begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end

            if ((r_state == ST_SHIFT) & w_ss_rise) begin
                r_cnt      <= 3'd0;
                r_rx_shift <= 8'h00;
            end else if (w_rx_bit) begin
                r_rx_shift <= {r_rx_shift[6:0], w_mosi};
                r_cnt      <= r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    r_rx_data  <= {r_rx_shift[6:0], w_mosi};
                    r_rx_valid <= 1'b1;
                end
            end
        end
    end

    assign MISO     = (r_state == ST_SHIFT) ? r_tx_shift[7] : 1'b1;
    assign MISO_OE  = (r_state == ST_SHIFT);
    assign TX_READY = ~r_hold_full;
    assign RX_DATA  = r_rx_data;
    assign RX_VALID = r_rx_valid;
    assign UNDERRUN = r_underrun;
    assign BUSY     = (r_state == ST_SHIFT) & (r_cnt != 3'd0);

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: stimulus pushes expected MISO/RX bytes into
// queues, independent monitors pop and compare as the DUT produces them.
module tb_spi_target;

    logic       MHZ48 = 1'b0;
    logic       RES = 1'b1;
    logic       nSS = 1'b0;
    logic       SCLK = 1'b0;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic       MISO_OE;
    logic [7:0] TX_DATA = 8'h00;
    logic       TX_VALID = 1'b0;
    logic       TX_READY;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       UNDERRUN;
    logic       BUSY;

    spi_target #(.FILL(8'hFF), .SYNC_STAGES(2)) dut (
        .MHZ48(MHZ48), .RES(RES), .nSS(nSS), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .TX_READY(TX_READY), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .UNDERRUN(UNDERRUN), .BUSY(BUSY)
    );

    always #5 MHZ48 = ~MHZ48;

    int total = 0;
    int bad = 0;
    int un_seen = 0;
    int exp_un = 0;
    bit mon_en = 1'b0;
    logic [7:0] q_miso[$];
    logic [7:0] q_rx[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge MHZ48);
        #1;
    endtask

    // RX and UNDERRUN monitor
    always @(negedge MHZ48) begin
        if (UNDERRUN === 1'b1) un_seen++;
        if (RX_VALID === 1'b1) begin
            if (q_rx.size() == 0) begin
                chk("rx_unexpected", {24'h0, RX_DATA}, 32'hFFFF_FFFF);
            end else begin
                chk("rx_byte", {24'h0, RX_DATA}, {24'h0, q_rx.pop_front()});
            end
        end
    end

    // MISO monitor: initiator view, sampling on SCLK rising edges while selected
    int         mbits = 0;
    logic [7:0] mbyte = 8'h00;
    always @(posedge SCLK or posedge nSS) begin
        if (nSS) begin
            mbits = 0;
        end else if (mon_en) begin
            chk("miso_oe_bit", {31'h0, MISO_OE}, 32'h1);
            mbyte = {mbyte[6:0], MISO};
            mbits++;
            if (mbits == 8) begin
                mbits = 0;
                if (q_miso.size() == 0) begin
                    chk("miso_unexpected", {24'h0, mbyte}, 32'hFFFF_FFFF);
                end else begin
                    chk("miso_byte", {24'h0, mbyte}, {24'h0, q_miso.pop_front()});
                end
            end
        end
    end

    task automatic push(input logic [7:0] d);
        int n = 0;
        while (TX_READY !== 1'b1 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("push_ready", {31'h0, TX_READY}, 32'h1);
        TX_DATA  = d;
        TX_VALID = 1'b1;
        cyc(1);
        TX_VALID = 1'b0;
    endtask

    task automatic select();
        SCLK = 1'b0;
        nSS  = 1'b0;
        cyc(8);
    endtask

    // bit i goes out as data[nbits-1-i]; the last bit leaves SCLK high
    task automatic shift_bits(input logic [15:0] data, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            MOSI = data[nbits-1-i];
            cyc(8);
            SCLK = 1'b1;
            cyc(8);
            if (i != nbits - 1) SCLK = 1'b0;
        end
    endtask

    task automatic deselect();
        nSS = 1'b1;
        cyc(3);
        chk("desel_oe", {31'h0, MISO_OE}, 32'h0);
        chk("desel_busy", {31'h0, BUSY}, 32'h0);
        chk("desel_miso", {31'h0, MISO}, 32'h1);
        SCLK = 1'b0;
        cyc(6);
    endtask

    task automatic end_test(input string name);
        cyc(4);
        chk({name, "_rx_left"}, q_rx.size(), 0);
        chk({name, "_miso_left"}, q_miso.size(), 0);
        chk({name, "_underruns"}, un_seen, exp_un);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with nSS low and SCLK toggling
        for (int i = 0; i < 4; i++) begin
            SCLK = ~SCLK;
            cyc(2);
        end
        chk("rst_miso", {31'h0, MISO}, 32'h1);
        chk("rst_oe", {31'h0, MISO_OE}, 32'h0);
        chk("rst_ready", {31'h0, TX_READY}, 32'h1);
        chk("rst_rxv", {31'h0, RX_VALID}, 32'h0);
        chk("rst_rxd", {24'h0, RX_DATA}, 32'h0);
        chk("rst_busy", {31'h0, BUSY}, 32'h0);
        chk("rst_under", {31'h0, UNDERRUN}, 32'h0);
        nSS  = 1'b1;
        SCLK = 1'b0;
        cyc(4);
        RES = 1'b0;
        cyc(6);
        chk("post_rst_oe", {31'h0, MISO_OE}, 32'h0);
        mon_en = 1'b1;

        // Single exchange
        push(8'h3C);
        chk("single_full", {31'h0, TX_READY}, 32'h0);
        q_miso.push_back(8'h3C);
        q_rx.push_back(8'hA5);
        select();
        chk("single_ready_back", {31'h0, TX_READY}, 32'h1);
        chk("single_oe", {31'h0, MISO_OE}, 32'h1);
        shift_bits(16'h00A5, 8);
        chk("single_busy_end", {31'h0, BUSY}, 32'h0);
        deselect();
        end_test("single");

        // Underrun
        q_miso.push_back(8'hFF);
        q_rx.push_back(8'h00);
        exp_un++;
        select();
        shift_bits(16'h0000, 8);
        deselect();
        end_test("underrun");
        chk("underrun_rxd", {24'h0, RX_DATA}, 32'h0);

        // Back-to-back with refill during byte 1
        push(8'h12);
        q_miso.push_back(8'h12);
        q_miso.push_back(8'h34);
        q_rx.push_back(8'hC3);
        q_rx.push_back(8'h5A);
        select();
        push(8'h34);
        shift_bits(16'hC35A, 16);
        deselect();
        end_test("b2b");

        // Abort after 5 bits, then a full byte
        exp_un++;
        select();
        shift_bits(16'h0016, 5);
        chk("abort_busy_mid", {31'h0, BUSY}, 32'h1);
        deselect();
        end_test("abort");
        chk("abort_rxd_held", {24'h0, RX_DATA}, 32'h5A);
        push(8'h96);
        q_miso.push_back(8'h96);
        q_rx.push_back(8'h69);
        select();
        shift_bits(16'h0069, 8);
        deselect();
        end_test("after_abort");

        // SCLK toggles while deselected
        for (int i = 0; i < 16; i++) begin
            SCLK = ~SCLK;
            cyc(8);
        end
        chk("desel_toggle_oe", {31'h0, MISO_OE}, 32'h0);
        chk("desel_toggle_rxd", {24'h0, RX_DATA}, 32'h69);
        end_test("deselected");

        // TX accept in the exact nSS-fall LOAD cycle
        q_miso.push_back(8'hFF);
        q_miso.push_back(8'h77);
        q_rx.push_back(8'h81);
        q_rx.push_back(8'h7E);
        exp_un++;
        SCLK = 1'b0;
        nSS  = 1'b0;
        cyc(2);
        TX_DATA  = 8'h77;
        TX_VALID = 1'b1;
        cyc(1);
        TX_VALID = 1'b0;
        chk("same_cycle_full", {31'h0, TX_READY}, 32'h0);
        cyc(6);
        chk("same_cycle_oe", {31'h0, MISO_OE}, 32'h1);
        shift_bits(16'h817E, 16);
        deselect();
        end_test("same_cycle");
        chk("same_cycle_ready_end", {31'h0, TX_READY}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
SPI mode-0 target (responder) for the bit-banged SD/SPI initiator in the glue CPLD. Oversamples nSS, SCLK and MOSI in the MHZ48 domain and shifts bytes MSB first. Exposes a received-byte strobe and a single-entry transmit holding register with a valid/ready handshake. Used in peripheral-side logic, such as an SD-card emulator or a coprocessor link, that answers the CPU's SPI port at $FE2E/$FE2F/$FE31.

Parameters:
FILL  8'hFF  byte shifted out when the TX holding register is empty at a load point
SYNC_STAGES  2  synchronizer depth for nSS/SCLK/MOSI; legal values 2..3

Ports:
MHZ48  in  1  master clock; all state on its rising edge
RES  in  1  reset, synchronous, active-high
nSS  in  1  SPI chip select, active low, asynchronous
SCLK  in  1  SPI clock, idles low, asynchronous
MOSI  in  1  SPI data from the initiator, asynchronous
MISO  out  1  SPI data to the initiator
MISO_OE  out  1  tri-state enable for MISO; 1 only while selected
TX_DATA  in  8  byte to send
TX_VALID  in  1  TX_DATA is offered
TX_READY  out  1  holding register empty; a transfer occurs when TX_VALID & TX_READY
RX_DATA  out  8  last complete received byte; held until the next byte completes
RX_VALID  out  1  one-cycle pulse when RX_DATA updates
UNDERRUN  out  1  one-cycle pulse when FILL is loaded because the holding register is empty
BUSY  out  1  selected and bit count is not 0

Behaviour:
- Synchronization
  - nSS, SCLK and MOSI each pass through a SYNC_STAGES flop chain.
  - One more register per signal provides edge detection.
  - A pin edge is acted on SYNC_STAGES+1 MHZ48 cycles after it occurs.
  - Supported SCLK: high and low phases of at least 4 MHZ48 cycles each.
- Reset (RES=1 at a clock edge), outputs:
  - MISO=1, MISO_OE=0
  - RX_DATA=0, RX_VALID=0, UNDERRUN=0, BUSY=0
  - TX_READY=1 (holding register empty)
  - State IDLE, bit count 0, shift registers 0
  - Reset overrides all other events in the same cycle, including mid-byte.
- State machine:
  - IDLE: nSS synchronized high. MISO_OE=0, MISO=1, SCLK edges ignored.
    - On the nSS falling edge: perform a LOAD and go to SHIFT.
  - LOAD:
    - If the holding register is full, the shifter takes it and the holding register empties (TX_READY rises the next cycle).
    - Otherwise the shifter takes FILL and UNDERRUN pulses.
    - MISO = shifter bit 7 from the cycle after the load. MISO_OE=1 from the nSS falling-edge cycle onward.
  - SHIFT:
    - On the synchronized SCLK rising edge: rx_shift <= {rx_shift[6:0], MOSI_sync}; count increments.
    - When count goes 7->0, the completed byte {rx_shift[6:0], MOSI_sync} goes to RX_DATA and RX_VALID pulses.
    - On the SCLK falling edge with count != 0: the tx shifter shifts left and MISO takes the new bit 7.
    - On the SCLK falling edge with count == 0 (after a completed byte): perform a LOAD for the next byte.
    - On the nSS rising edge: go to IDLE the same cycle.
      - The partial RX byte is discarded with no RX_VALID; count=0; MISO_OE=0, MISO=1.
      - The holding register is untouched.
- Holding register:
  - Accepts on TX_VALID & TX_READY; TX_DATA is captured.
  - A LOAD sees the registered empty/full state. A byte accepted in the same cycle as a LOAD is not bypassed: that LOAD uses FILL (and flags UNDERRUN), and the accepted byte waits for the next LOAD.
- RX has no backpressure. A consumer that misses RX_VALID loses the byte.
- BUSY = (state==SHIFT) & (count!=0).
- Rising and falling SCLK edges never occur in the same cycle (guaranteed by the synchronizer). If nSS rises in the same cycle as an SCLK edge, the nSS edge wins and the SCLK edge is ignored.

Test Plan:
- Reset: assert RES for 2 cycles with nSS=0 and SCLK toggling -> MISO=1, MISO_OE=0, TX_READY=1, RX_VALID=0, RX_DATA=8'h00.
- Single exchange: push TX_DATA=8'h3C, drop nSS, clock 8 bits of 8'hA5 on MOSI (SCLK phases of 8 cycles) -> MISO bits sampled on rising edges = 0,0,1,1,1,1,0,0; one RX_VALID pulse with RX_DATA=8'hA5; TX_READY returns to 1 after the LOAD.
- Underrun: select with the holding register empty, send 8'h00 -> MISO yields 8'hFF, UNDERRUN pulses once at selection, RX_DATA=8'h00.
- Back-to-back: preload 8'h12, refill 8'h34 during byte 1, clock 16 bits of 8'hC3,8'h5A -> MISO stream 8'h12 then 8'h34; RX_VALID pulses twice, carrying 8'hC3 then 8'h5A; no UNDERRUN.
- Abort: select, clock 5 bits, raise nSS -> no RX_VALID, MISO_OE=0 within SYNC_STAGES+1 cycles, BUSY=0; the next selection receives a full byte correctly.
- Deselected and same-cycle accept: toggle SCLK 8 times with nSS=1 -> no RX_VALID, MISO_OE=0. Assert TX_VALID with 8'h77 exactly in the nSS-fall LOAD cycle with the register empty -> first byte is FILL with UNDERRUN; 8'h77 goes out as the second byte.
